eq_serial_ctrl: RTL and testbench

EQ_SERIAL_CTRL -- requirements
Module: eq_serial_ctrl

---
 rtl/eq_ctrl_pkg.sv | 13 +
 rtl/eq_2_sop.sv | 14 +
 rtl/eq_serial_ctrl.sv | 100 ++++++++++
 tb/tb_eq_serial_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/eq_ctrl_pkg.sv
// Shared types and constants for the serial 2-bit-digit equality controller.
`timescale 1ns/1ps
package eq_ctrl_pkg;

  localparam int DIGIT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/eq_2_sop.sv
// Combinational 2-bit equality comparator in sum-of-products form.
`timescale 1ns/1ps
module eq_2_sop (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       aeqb
);

  assign aeqb = (~a[1] & ~a[0] & ~b[1] & ~b[0]) |
                (~a[1] &  a[0] & ~b[1] &  b[0]) |
                ( a[1] & ~a[0] &  b[1] & ~b[0]) |
                ( a[1] &  a[0] &  b[1] &  b[0]);

endmodule

// File: rtl/eq_serial_ctrl.sv
// Serial A==B comparator: walks both operands one 2-bit digit per cycle,
// LSB digit first, through a single shared comparator with early exit on mismatch.
`timescale 1ns/1ps
module eq_serial_ctrl
  import eq_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             aeqb
);

  localparam int N     = WIDTH / DIGIT_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, b_sh_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             match_reg;
  logic             aeqb_reg;
  logic             digit_eq;
  logic             accept;
  logic             last_digit;

  assign accept     = (state_reg == IDLE) && start && !abort;
  assign last_digit = (cnt_reg == LAST_DIGIT);

  eq_2_sop u_digit_cmp (
    .a    (a_sh_reg[DIGIT_W-1:0]),
    .b    (b_sh_reg[DIGIT_W-1:0]),
    .aeqb (digit_eq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = RUN;
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (!digit_eq || last_digit) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The counter only advances on a matching non-final digit, so it cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      cnt_reg   <= '0;
      match_reg <= 1'b0;
      aeqb_reg  <= 1'b0;
    end else if (accept) begin
      a_sh_reg  <= a;
      b_sh_reg  <= b;
      cnt_reg   <= '0;
      match_reg <= 1'b1;
      aeqb_reg  <= 1'b0;
    end else if (state_reg == RUN && !abort) begin
      a_sh_reg <= a_sh_reg >> DIGIT_W;
      b_sh_reg <= b_sh_reg >> DIGIT_W;
      if (!digit_eq) begin
        match_reg <= 1'b0;
        aeqb_reg  <= 1'b0;
      end else if (last_digit) begin
        aeqb_reg <= match_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign ready = (state_reg == IDLE);
  assign busy  = (state_reg == RUN);
  assign done  = (state_reg == DONE);
  assign aeqb  = aeqb_reg;

endmodule

// File: tb/tb_eq_serial_ctrl.sv
// Scoreboard bench for eq_serial_ctrl (WIDTH=8): expected result and done cycle
// are queued when a compare is accepted and checked when done pulses.
`timescale 1ns/1ps
module tb_eq_serial_ctrl;

  localparam int WIDTH = 8;
  localparam int N     = WIDTH / 2;

  typedef struct {
    logic eq;
    int   cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] a_in = '0;
  logic [WIDTH-1:0] b_in = '0;
  logic             ready, busy, done, aeqb;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t sb[$];

  eq_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .a     (a_in),
    .b     (b_in),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .aeqb  (aeqb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: done cycle index relative to the start edge.
  function automatic int model_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    for (int d = 0; d < N; d++) begin
      if (x[2*d +: 2] != y[2*d +: 2]) return d + 2;
    end
    return N + 1;
  endfunction

  // c1 is the cycle counter value during "cycle 1" (first cycle after the start edge).
  task automatic push_exp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input int c1);
    exp_t e;
    e.eq  = (x == y);
    e.cyc = c1 + model_lat(x, y) - 1;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check_val("spurious_done", int'(done), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("aeqb_at_done", int'(aeqb), int'(e.eq));
        check_val("done_cycle", cyc, e.cyc);
        $display("compare done: cycle %0d aeqb=%0d", cyc, aeqb);
      end
    end
  end

  task automatic wait_done(output int busy_cnt);
    int n;
    n = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (busy) busy_cnt++;
    end
    check_val("done_seen", int'(done), 1);
  endtask

  // Entered and left on a negedge.
  task automatic run_cmp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input bit alter);
    int bc;
    int n;
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    a_in  = x;
    b_in  = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    push_exp(x, y, cyc);
    $display("start a=%h b=%h", x, y);
    check_val("busy_cycle1", int'(busy), 1);
    if (alter) begin
      a_in = '0;
      b_in = 8'hFF;
    end
    wait_done(bc);
    check_val("busy_cycles", bc, model_lat(x, y) - 1);
    @(negedge clk);
    check_val("ready_after", int'(ready), 1);
    check_val("aeqb_hold", int'(aeqb), int'(x == y));
  endtask

  initial begin
    int bc;
    repeat (3) @(negedge clk);
    check_val("rst_ready", int'(ready), 1);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_aeqb", int'(aeqb), 0);

    // Start accepted on the very first edge after release.
    rst_n = 1'b1;
    run_cmp(8'hA5, 8'hA5, 1'b0);
    run_cmp(8'hA5, 8'hA4, 1'b0);
    run_cmp(8'h3C, 8'h7C, 1'b1);
    run_cmp(8'h1B, 8'h0B, 1'b0);

    // start held through RUN and DONE: ignored there, re-accepted only in IDLE.
    a_in  = 8'h11;
    b_in  = 8'h11;
    start = 1'b1;
    @(negedge clk);
    push_exp(8'h11, 8'h11, cyc);
    wait_done(bc);
    check_val("held_busy_cycles", bc, N);
    @(negedge clk);
    check_val("held_ready_after_done", int'(ready), 1);
    check_val("held_busy_after_done", int'(busy), 0);
    a_in = 8'h12;
    @(negedge clk);
    start = 1'b0;
    push_exp(8'h12, 8'h11, cyc);
    wait_done(bc);
    @(negedge clk);
    check_val("held_sb_empty", sb.size(), 0);

    // Abort in cycle 2 of an equal compare, after a result of 1 was left in aeqb.
    run_cmp(8'hFF, 8'hFF, 1'b0);
    a_in  = 8'hA5;
    b_in  = 8'hA5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("abort_busy_c1", int'(busy), 1);
    check_val("abort_aeqb_cleared", int'(aeqb), 0);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_val("abort_ready", int'(ready), 1);
    check_val("abort_busy", int'(busy), 0);
    check_val("abort_aeqb", int'(aeqb), 0);
    repeat (8) @(negedge clk);
    $display("abort in cycle 2: no done expected");

    // start and abort together in IDLE.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_val("startabort_ready", int'(ready), 1);
    check_val("startabort_busy", int'(busy), 0);
    $display("start+abort in IDLE: not accepted");

    // Asynchronous reset in the middle of RUN.
    a_in  = 8'h55;
    b_in  = 8'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_val("prereset_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_ready", int'(ready), 1);
    check_val("arst_busy", int'(busy), 0);
    check_val("arst_done", int'(done), 0);
    check_val("arst_aeqb", int'(aeqb), 0);
    $display("async reset mid-RUN");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check_val("postreset_ready", int'(ready), 1);

    run_cmp(8'h96, 8'h96, 1'b0);
    run_cmp(8'h96, 8'hD6, 1'b0);
    check_val("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "time limit");
  end

endmodule
